// File: rtl/mem_stage_pipe.sv
// mem_stage_pipe: M->W pipeline register with byte-addressable data memory and an LAT-cycle access FSM.
// Optional MEM_MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of silently aligning them.
module mem_stage_pipe #(
  parameter int DEPTH = 256,
  parameter int LAT   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        valid_m,
  input  logic        reg_write_m,
  input  logic        mem_read_m,
  input  logic        mem_write_m,
  input  logic [1:0]  result_src_m,
  input  logic [2:0]  funct3_m,
  input  logic [4:0]  rd_m,
  input  logic [31:0] alu_result_m,
  input  logic [31:0] write_data_m,
  input  logic [31:0] pc_plus4_m,
  output logic        busy_o,
  output logic        valid_w,
  output logic        reg_write_w,
  output logic [1:0]  result_src_w,
  output logic [4:0]  rd_w,
  output logic [31:0] alu_result_w,
  output logic [31:0] pc_plus4_w,
  output logic [31:0] read_data_w,
  output logic        misalign_w
);
  localparam int         AW    = $clog2(DEPTH);
  localparam logic [3:0] LAT_C = 4'(LAT);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic [1:0]  result_src;
    logic [4:0]  rd;
    logic [31:0] alu_result;
    logic [31:0] pc_plus4;
    logic [31:0] read_data;
    logic        misalign;
  } w_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  w_t          w_q, w_d;
  logic [31:0] mem [DEPTH];

  logic          mem_op, busy, capture, do_write, misalign, trap;
  logic          is_half, is_word;
  logic [1:0]    off;
  logic [AW-1:0] idx;
  logic [31:0]   rword, rdata, wmask, wdata;
  logic [15:0]   lane;

  assign mem_op  = valid_m && (mem_read_m || mem_write_m);
  assign idx     = alu_result_m[AW+1:2];
  assign is_half = (funct3_m[1:0] == 2'b01);
  assign is_word = (funct3_m == 3'b010);
  assign misalign = (is_half && alu_result_m[0]) || (is_word && (alu_result_m[1:0] != 2'b00));

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = mem_op && misalign;
  assign off  = alu_result_m[1:0];
`else
  assign trap = 1'b0;
  assign off  = misalign ? (is_half ? {alu_result_m[1], 1'b0} : 2'b00) : alu_result_m[1:0];
`endif

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    busy = 1'b0;
    if (state_q == S_IDLE) busy = mem_op && (LAT != 0) && !flush_i;
    else                   busy = (cnt_q != LAT_C);
  end

  // busy is gated by rst so it reads 0 during reset whatever the M inputs do
  assign busy_o   = busy && rst;
  assign capture  = !flush_i && !stall_i && !busy;
  assign do_write = capture && mem_op && mem_write_m && !trap;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (!stall_i) begin
      case (state_q)
        S_IDLE: if (busy) begin
          state_d = S_WAIT;
          cnt_d   = 4'd1;
        end
        S_WAIT: if (cnt_q == LAT_C) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments only, so every reader sees the pre-edge value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    wmask = '0;
    wdata = '0;
    case (funct3_m)
      3'b000: begin
        wmask = 32'h0000_00FF << {off, 3'b000};
        wdata = {4{write_data_m[7:0]}};
      end
      3'b001: begin
        wmask = 32'h0000_FFFF << {off, 3'b000};
        wdata = {2{write_data_m[15:0]}};
      end
      3'b010: begin
        wmask = '1;
        wdata = write_data_m;
      end
      default: ;
    endcase
  end

  assign rword = mem[idx];
  assign lane  = 16'(rword >> {off, 3'b000});

  always_comb begin
    rdata = '0;
    case (funct3_m)
      3'b000:  rdata = {{24{lane[7]}}, lane[7:0]};
      3'b001:  rdata = {{16{lane[15]}}, lane};
      3'b010:  rdata = rword;
      3'b100:  rdata = {24'h0, lane[7:0]};
      3'b101:  rdata = {16'h0, lane};
      default: rdata = '0;
    endcase
  end

  // NOTE: the memory has a real asynchronous clear because its contents must read 0 after reset;
  // this rules out a RAM macro and builds the array from resettable flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_write) begin
      mem[idx] <= (mem[idx] & ~wmask) | (wdata & wmask);
    end
  end

  always_comb begin
    w_d = w_q;
    if (flush_i || (!stall_i && (busy || !valid_m))) begin
      w_d = '0;
    end else if (!stall_i) begin
      w_d.valid      = 1'b1;
      w_d.reg_write  = reg_write_m && !trap;
      w_d.result_src = result_src_m;
      w_d.rd         = rd_m;
      w_d.alu_result = alu_result_m;
      w_d.pc_plus4   = pc_plus4_m;
      w_d.read_data  = (mem_read_m && !trap) ? rdata : 32'h0;
      w_d.misalign   = trap;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) w_q <= '0;
    else      w_q <= w_d;
  end

  assign valid_w      = w_q.valid;
  assign reg_write_w  = w_q.reg_write;
  assign result_src_w = w_q.result_src;
  assign rd_w         = w_q.rd;
  assign alu_result_w = w_q.alu_result;
  assign pc_plus4_w   = w_q.pc_plus4;
  assign read_data_w  = w_q.read_data;
  assign misalign_w   = w_q.misalign;

endmodule

// File: doc/mem_stage_pipe.md
MEM_STAGE_PIPE -- requirements
Module: mem_stage_pipe

Interface
REQ-001 Parameter DEPTH, default 256, SHALL set data memory size in 32-bit words; must be a power of two.
REQ-002 Parameter LAT, default 0, SHALL set extra wait cycles per load/store; legal range 0..15.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 stall_i  in  1  writeback hold: W registers and FSM frozen.
REQ-006 flush_i  in  1  kill current M instruction.
REQ-007 valid_m  in  1  M-stage instruction valid.
REQ-008 reg_write_m, mem_read_m, mem_write_m  in  1 each  M control.
REQ-009 result_src_m  in  2  writeback select: 00 ALU, 01 load, 10 PC+4.
REQ-010 funct3_m  in  3  access size/sign.
REQ-011 rd_m  in  5  destination register.
REQ-012 alu_result_m, write_data_m, pc_plus4_m  in  32 each  address/ALU result, store data, PC+4.
REQ-013 busy_o  out  1  upstream stall request while an access is pending.
REQ-014 valid_w, reg_write_w  out  1 each; result_src_w  out  2; rd_w  out  5.
REQ-015 alu_result_w, pc_plus4_w, read_data_w  out  32 each; misalign_w  out  1.

Function
REQ-016 Word index SHALL be alu_result_m[log2(DEPTH)+1:2]; higher address bits ignored (wrap).
REQ-017 Stores: funct3 000 SB, 001 SH, 010 SW, writing only the addressed byte lanes, little-endian.
REQ-018 Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; byte/half selected by alu_result_m[1:0], sign- or zero-extended to 32 bits.
REQ-019 Other funct3 values on a memory access SHALL perform no write and return read_data_w = 0.
REQ-020 FSM states IDLE and WAIT; IDLE->WAIT when valid_m and (mem_read_m|mem_write_m) and LAT>0 and no flush; WAIT counts LAT cycles then returns to IDLE.
REQ-021 busy_o SHALL be 1 in IDLE on the triggering cycle and in WAIT except its final cycle; LAT=0 SHALL never assert busy_o.
REQ-022 An access completes on the edge where busy_o=0, stall_i=0, flush_i=0; store SHALL be written exactly once at that edge, load data captured into read_data_w at that edge.
REQ-023 On a completing edge W registers SHALL capture all M fields; total latency M->W = LAT+1 cycles for memory ops, 1 cycle otherwise.
REQ-024 While busy_o=1 and stall_i=0, W registers SHALL capture a bubble (valid_w=0, reg_write_w=0, others 0).
REQ-025 stall_i=1 SHALL hold all W outputs and FSM state/counter; no memory write occurs.
REQ-026 flush_i SHALL have priority over stall_i and busy: FSM to IDLE, counter cleared, no write, bubble captured next edge.
REQ-027 valid_m=0 SHALL be treated as a bubble: no memory access, valid_w=0, reg_write_w=0.
REQ-028 Read-after-write to same word on consecutive completing instructions SHALL return the new data.

Reset
REQ-029 rst=0 SHALL asynchronously force all W outputs, busy_o and misalign_w to 0, FSM to IDLE, counter to 0; memory contents SHALL be cleared to 0.
REQ-030 Reset asserted mid-WAIT SHALL abandon the access with no memory write.

Configuration
REQ-031 Macro MEM_MISALIGN_TRAP_EN defined: halfword with addr[0]=1 or word with addr[1:0]!=0 SHALL suppress the write, force reg_write_w=0, and set misalign_w=1 for that W cycle.
REQ-032 Macro undefined: offending low address bits SHALL be forced to 0 (aligned access), misalign_w tied 0.

Verification
REQ-033 LAT=0: SW 0xDEADBEEF to 0x10, then LW 0x10 -> read_data_w=0xDEADBEEF one cycle after LW in M.
REQ-034 SB 0x80 to 0x13 after SW 0 at 0x10; LB 0x13 -> 0xFFFFFF80, LBU 0x13 -> 0x00000080, LW 0x10 -> 0x80000000.
REQ-035 LAT=3: LW issued -> busy_o high 3 cycles, 3 bubbles at W (valid_w=0), data valid on 4th edge.
REQ-036 flush_i during WAIT of SW 0x1234 to 0x20 -> later LW 0x20 returns 0; stall_i=1 for 2 cycles holds rd_w/alu_result_w unchanged.
REQ-037 With MEM_MISALIGN_TRAP_EN: SH to 0x21 -> misalign_w=1, reg_write_w=0, memory word 0x20 unchanged; without: writes halfword at 0x20.
REQ-038 rst pulsed low mid-WAIT -> all outputs 0 immediately, pending store not written.
